// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage RISC-V pipeline: stage enables, bubble/flush strobes, EX forwarding selects.
// Define HAZARD_FORWARD_EN for forwarding with load-use stalls; left undefined, RAW stalls replace forwarding.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              memwb_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Shadow records; MEM and WB keep only the fields something downstream reads.
  logic [REG_AW-1:0] r_ex_rd;
  logic [REG_AW-1:0] r_ex_rs1;
  logic [REG_AW-1:0] r_ex_rs2;
  logic              r_ex_we;
  logic              r_ex_mr;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_we;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_we;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_memstall;
  logic w_hazard;
  logic w_ex_hit_rs1;
  logic w_ex_hit_rs2;

  assign w_memstall   = mem_req & ~mem_ready;
  assign w_ex_hit_rs1 = r_ex_we & (r_ex_rd != REG_ZERO) & (r_ex_rd == id_rs1);
  assign w_ex_hit_rs2 = r_ex_we & (r_ex_rd != REG_ZERO) & (r_ex_rd == id_rs2);

`ifdef HAZARD_FORWARD_EN
  function automatic logic [1:0] fwd_src(
    input logic [REG_AW-1:0] rs,
    input logic              mem_we,
    input logic [REG_AW-1:0] mem_rd,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_rd
  );
    logic [1:0] sel;
    if (mem_we && (mem_rd != REG_ZERO) && (mem_rd == rs)) begin
      sel = 2'b10;
    end else if (wb_we && (wb_rd != REG_ZERO) && (wb_rd == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign w_hazard = id_valid & r_ex_mr &
                    ((id_use_rs1 & w_ex_hit_rs1) | (id_use_rs2 & w_ex_hit_rs2));

  // EX operand source selection, youngest producer first.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rstn) begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end else begin
      fwd_a = fwd_src(r_ex_rs1, r_mem_we, r_mem_rd, r_wb_we, r_wb_rd);
      fwd_b = fwd_src(r_ex_rs2, r_mem_we, r_mem_rd, r_wb_we, r_wb_rd);
    end
  end
`else
  logic w_mem_hit_rs1;
  logic w_mem_hit_rs2;
  logic w_unused;

  assign w_mem_hit_rs1 = r_mem_we & (r_mem_rd != REG_ZERO) & (r_mem_rd == id_rs1);
  assign w_mem_hit_rs2 = r_mem_we & (r_mem_rd != REG_ZERO) & (r_mem_rd == id_rs2);
  // Without forwarding, a reader waits until its producer sits in WB.
  assign w_hazard = id_valid &
                    ((id_use_rs1 & (w_ex_hit_rs1 | w_mem_hit_rs1)) |
                     (id_use_rs2 & (w_ex_hit_rs2 | w_mem_hit_rs2)));
  assign fwd_a    = 2'b00;
  assign fwd_b    = 2'b00;
  assign w_unused = ^{r_ex_mr, r_ex_rs1, r_ex_rs2, r_wb_rd, r_wb_we};
`endif

  // Stage enables and flush strobes in priority order: reset, memory stall, redirect, hazard.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    memwb_flush = 1'b0;
    if (!rstn) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_en     = 1'b0;
      idex_flush  = 1'b1;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (w_memstall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (w_hazard) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_flush  = 1'b1;
    end else begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
    end
  end

  // Shadow pipeline advances with the same enables/flushes the real pipeline receives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ex_rd  <= REG_ZERO;
      r_ex_rs1 <= REG_ZERO;
      r_ex_rs2 <= REG_ZERO;
      r_ex_we  <= 1'b0;
      r_ex_mr  <= 1'b0;
      r_mem_rd <= REG_ZERO;
      r_mem_we <= 1'b0;
      r_wb_rd  <= REG_ZERO;
      r_wb_we  <= 1'b0;
    end else begin
      if (idex_en) begin
        if (idex_flush || !id_valid) begin
          r_ex_rd  <= REG_ZERO;
          r_ex_rs1 <= REG_ZERO;
          r_ex_rs2 <= REG_ZERO;
          r_ex_we  <= 1'b0;
          r_ex_mr  <= 1'b0;
        end else begin
          r_ex_rd  <= id_rd;
          r_ex_rs1 <= id_rs1;
          r_ex_rs2 <= id_rs2;
          r_ex_we  <= id_regwrite;
          r_ex_mr  <= id_memread;
        end
      end
      if (exmem_en) begin
        r_mem_rd <= r_ex_rd;
        r_mem_we <= r_ex_we;
      end
      if (memwb_flush) begin
        r_wb_rd <= REG_ZERO;
        r_wb_we <= 1'b0;
      end else begin
        r_wb_rd <= r_mem_rd;
        r_wb_we <= r_mem_we;
      end
    end
  end

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (!pc_en) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (ex_redirect && !w_memstall) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed pipeline scenarios with literal expectations, then random traffic
// against a stage-array reference model checked every cycle.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // control vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
  localparam logic [6:0] NORM  = 7'b1101010;
  localparam logic [6:0] RESET = 7'b0010101;
  localparam logic [6:0] HAZ   = 7'b0001110;
  localparam logic [6:0] REDIR = 7'b1111110;
  localparam logic [6:0] MEMST = 7'b0000001;

  logic        clk = 1'b0;
  logic        rstn;
  logic        id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_redirect, mem_req, mem_ready;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .memwb_flush(memwb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       mr;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } rec_t;

  typedef struct packed {
    logic [6:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  rec_t        pm [3];   // 0 = EX, 1 = MEM, 2 = WB
  int unsigned m_stall;
  int unsigned m_flush;
  exp_t        m_e;

  function automatic bit writes(rec_t r, logic [4:0] a);
    return r.we && (r.rd != 5'd0) && (r.rd == a);
  endfunction

  function automatic logic [1:0] source_of(logic [4:0] rs);
    if (writes(pm[1], rs)) return 2'b10;
    if (writes(pm[2], rs)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t model();
    exp_t e;
    bit   haz;
    int   last;
    e.ctl = NORM;
    e.fa  = 2'b00;
    e.fb  = 2'b00;
    if (!rstn) begin
      e.ctl = RESET;
      return e;
    end
    // with forwarding only a load in EX blocks; without it any producer in EX or MEM
    last = FWD ? 0 : 1;
    haz  = 1'b0;
    for (int s = 0; s <= last; s++) begin
      if (id_valid && (!FWD || pm[s].mr) &&
          ((id_use_rs1 && writes(pm[s], id_rs1)) || (id_use_rs2 && writes(pm[s], id_rs2))))
        haz = 1'b1;
    end
    if (mem_req && !mem_ready) e.ctl = MEMST;
    else if (ex_redirect)      e.ctl = REDIR;
    else if (haz)              e.ctl = HAZ;
    if (FWD) begin
      e.fa = source_of(pm[0].rs1);
      e.fb = source_of(pm[0].rs2);
    end
    return e;
  endfunction

  always_comb m_e = model();

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pm[0]   <= '0;
      pm[1]   <= '0;
      pm[2]   <= '0;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      if (!m_e.ctl[6]) m_stall <= m_stall + 1;
      if (ex_redirect && !(mem_req && !mem_ready)) m_flush <= m_flush + 1;
      pm[2] <= m_e.ctl[0] ? rec_t'(0) : pm[1];
      if (m_e.ctl[1]) pm[1] <= pm[0];
      if (m_e.ctl[3])
        pm[0] <= (m_e.ctl[2] || !id_valid) ? rec_t'(0) :
                 rec_t'{rd: id_rd, we: id_regwrite, mr: id_memread, rs1: id_rs1, rs2: id_rs2};
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl();
    return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush};
  endfunction

  always @(negedge clk) begin
    chk("model_ctl", {25'd0, ctl()}, {25'd0, m_e.ctl});
    chk("model_fwd_a", {30'd0, fwd_a}, {30'd0, m_e.fa});
    chk("model_fwd_b", {30'd0, fwd_b}, {30'd0, m_e.fb});
    chk("model_stall_cnt", stall_cnt, m_stall);
    chk("model_flush_cnt", flush_cnt, m_flush);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic we, input logic mr);
    id_valid = 1'b1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; id_regwrite = we; id_memread = mr;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    repeat (3) begin next(); idle(); end
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", {25'd0, ctl()}, {25'd0, RESET});
    chk("reset_fwd_a", {30'd0, fwd_a}, 32'd0);
    rstn = 1'b1;
    settle();
    chk("idle_ctl", {25'd0, ctl()}, {25'd0, NORM});
    chk("idle_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("idle_stall_cnt", stall_cnt, 32'd0);
    chk("idle_flush_cnt", flush_cnt, 32'd0);

    // lw x5 ; add x6,x5,x7
    next(); issue(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    settle(); chk("lw_issue", {25'd0, ctl()}, {25'd0, NORM});
    next(); issue(5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    settle(); chk("lu_stall", {25'd0, ctl()}, {25'd0, HAZ});
    next();
    settle(); chk("lu_second", {25'd0, ctl()}, {25'd0, (FWD ? NORM : HAZ)});
    next(); id_valid = !FWD;
    settle();
    chk("lu_fwd_a", {30'd0, fwd_a}, (FWD ? 32'd1 : 32'd0));
    chk("lu_stall_cnt", stall_cnt, (FWD ? 32'd1 : 32'd2));
    chk("lu_resume", {25'd0, ctl()}, {25'd0, NORM});
    drain();

    // add x3 ; sub x4,x3,x3
    next(); issue(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    next(); issue(5'd4, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    settle(); chk("raw_first", {25'd0, ctl()}, {25'd0, (FWD ? NORM : HAZ)});
    next(); id_valid = !FWD;
    settle();
    chk("raw_fwd_a", {30'd0, fwd_a}, (FWD ? 32'd2 : 32'd0));
    chk("raw_fwd_b", {30'd0, fwd_b}, (FWD ? 32'd2 : 32'd0));
    chk("raw_second", {25'd0, ctl()}, {25'd0, (FWD ? NORM : HAZ)});
    next(); id_valid = !FWD;
    settle();
    chk("raw_stall_cnt", stall_cnt, (FWD ? 32'd1 : 32'd4));
    chk("raw_resume", {25'd0, ctl()}, {25'd0, NORM});
    next(); idle();
    settle(); chk("raw_late_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    drain();

    // redirect while a load-use match sits in ID
    next(); issue(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    settle();
    next(); issue(5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0); ex_redirect = 1'b1;
    settle();
    chk("redir_ctl", {25'd0, ctl()}, {25'd0, REDIR});
    chk("redir_flush_before", flush_cnt, 32'd0);
    next(); idle();
    settle();
    chk("redir_flush_after", flush_cnt, 32'd1);
    chk("redir_no_stall", stall_cnt, (FWD ? 32'd1 : 32'd4));
    drain();

    // memory stall holding off a redirect for three cycles
    next(); idle(); mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1;
    repeat (3) begin
      settle(); chk("memstall_ctl", {25'd0, ctl()}, {25'd0, MEMST});
      next();
    end
    mem_ready = 1'b1;
    settle();
    chk("memdone_redir", {25'd0, ctl()}, {25'd0, REDIR});
    chk("memdone_flush_before", flush_cnt, 32'd1);
    next(); idle();
    settle();
    chk("memstall_stall_cnt", stall_cnt, (FWD ? 32'd4 : 32'd7));
    chk("memstall_flush_cnt", flush_cnt, 32'd2);
    drain();

    // x0 writer (a load) followed by x0 reader
    next(); issue(5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    next(); issue(5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    settle(); chk("x0_no_stall", {25'd0, ctl()}, {25'd0, NORM});
    next(); idle();
    settle(); chk("x0_no_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    drain();

    // asynchronous reset in the middle of a stall
    next(); issue(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    settle();
    next(); issue(5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    settle(); chk("pre_rst_stall", {25'd0, ctl()}, {25'd0, HAZ});
    #1 rstn = 1'b0;
    #1 chk("mid_rst_ctl", {25'd0, ctl()}, {25'd0, RESET});
    next(); rstn = 1'b1;
    settle();
    chk("post_rst_ctl", {25'd0, ctl()}, {25'd0, NORM});
    chk("post_rst_stall_cnt", stall_cnt, 32'd0);
    chk("post_rst_flush_cnt", flush_cnt, 32'd0);

    // random traffic with a small register range so hazards are frequent
    repeat (3000) begin
      next();
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_rd       = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      id_regwrite = ($urandom_range(0, 3) != 0);
      id_memread  = 1'($urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 7) == 0);
      mem_req     = ($urandom_range(0, 2) == 0);
      mem_ready   = 1'($urandom_range(0, 1));
      rstn        = ($urandom_range(0, 199) != 0);
    end
    settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
